// File: rtl/cal1d_fp16_pool_sum_seq.sv
// ---------------------------------------------------------------------------
// cal1d_fp16_pool_sum_seq
//
// Sequencer for the 4-lane fp17 pool-sum adder array in the PDP 1D pooling
// path. Collects a window of K = cfg_kernel_width + 1 input vectors into one
// sum vector. The first element of a window is copied into the accumulator.
// Each later element is sent to the external adder together with the
// accumulator, and the adder result is written back into the accumulator.
// Only one add is ever outstanding.
//
// Ports
//   nvdla_core_clk / nvdla_core_rst : clock, asynchronous active-high reset
//   cfg_kernel_width               : window size minus one, sampled on the
//                                    first element of each window
//   in_pvld / in_prdy / in_data_*  : input element stream (4 x fp17)
//   add_in_pvld / add_in_prdy      : operand handshake to the adder
//   add_a_* / add_b_*              : adder operands (accumulator, element)
//   add_out_pvld / add_out_prdy    : result handshake from the adder
//   add_z_*                        : adder result lanes
//   out_pvld / out_prdy / out_z_*  : window sum stream (4 x fp17)
//   busy                           : high whenever a window is in progress
// ---------------------------------------------------------------------------
module cal1d_fp16_pool_sum_seq #(
    parameter int KW_BITS = 3
) (
    input  logic               nvdla_core_clk,
    input  logic               nvdla_core_rst,
    input  logic [KW_BITS-1:0] cfg_kernel_width,

    input  logic               in_pvld,
    output logic               in_prdy,
    input  logic [16:0]        in_data_0,
    input  logic [16:0]        in_data_1,
    input  logic [16:0]        in_data_2,
    input  logic [16:0]        in_data_3,

    output logic               add_in_pvld,
    input  logic               add_in_prdy,
    output logic [16:0]        add_a_0,
    output logic [16:0]        add_a_1,
    output logic [16:0]        add_a_2,
    output logic [16:0]        add_a_3,
    output logic [16:0]        add_b_0,
    output logic [16:0]        add_b_1,
    output logic [16:0]        add_b_2,
    output logic [16:0]        add_b_3,

    input  logic               add_out_pvld,
    output logic               add_out_prdy,
    input  logic [16:0]        add_z_0,
    input  logic [16:0]        add_z_1,
    input  logic [16:0]        add_z_2,
    input  logic [16:0]        add_z_3,

    output logic               out_pvld,
    input  logic               out_prdy,
    output logic [16:0]        out_z_0,
    output logic [16:0]        out_z_1,
    output logic [16:0]        out_z_2,
    output logic [16:0]        out_z_3,

    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t              state_q;
    logic [3:0][16:0]    acc_q;
    // One bit wider than the kernel field so K = 2^KW_BITS fits without wrap.
    logic [KW_BITS:0]    cnt_q;
    logic [KW_BITS-1:0]  kw_q;

    logic [3:0][16:0]    in_data;
    logic [3:0][16:0]    add_z;

    assign in_data = {in_data_3, in_data_2, in_data_1, in_data_0};
    assign add_z   = {add_z_3, add_z_2, add_z_1, add_z_0};

    // -----------------------------------------------------------------------
    // Control FSM. All lanes move together, so one accumulator register
    // vector is updated under a single enable.
    // -----------------------------------------------------------------------
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            kw_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_pvld) begin
                        // First element seeds the accumulator directly.
                        acc_q   <= in_data;
                        kw_q    <= cfg_kernel_width;
                        cnt_q   <= (KW_BITS+1)'(1);
                        state_q <= (cfg_kernel_width == '0) ? OUT : ISSUE;
                    end
                end
                ISSUE: begin
                    if (in_pvld && add_in_prdy) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // Adder latency is unbounded; simply park here.
                    if (add_out_pvld) begin
                        acc_q   <= add_z;
                        cnt_q   <= cnt_q + 1'b1;
                        // cnt_q counts elements already in acc before this add.
                        state_q <= (cnt_q == {1'b0, kw_q}) ? OUT : ISSUE;
                    end
                end
                OUT: begin
                    // Return to IDLE only; next window starts a cycle later.
                    if (out_prdy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output decode. Only the ISSUE-state handshake is a combinational
    // pass-through between the input stream and the adder input.
    // -----------------------------------------------------------------------
    assign in_prdy      = (state_q == IDLE) || ((state_q == ISSUE) && add_in_prdy);
    assign add_in_pvld  = (state_q == ISSUE) && in_pvld;
    assign add_out_prdy = (state_q == WAIT);
    assign out_pvld     = (state_q == OUT);
    assign busy         = (state_q != IDLE);

    assign add_a_0 = acc_q[0];
    assign add_a_1 = acc_q[1];
    assign add_a_2 = acc_q[2];
    assign add_a_3 = acc_q[3];

    assign add_b_0 = in_data[0];
    assign add_b_1 = in_data[1];
    assign add_b_2 = in_data[2];
    assign add_b_3 = in_data[3];

    assign out_z_0 = acc_q[0];
    assign out_z_1 = acc_q[1];
    assign out_z_2 = acc_q[2];
    assign out_z_3 = acc_q[3];

endmodule
